// File: rtl/seven_segment_scan_driver.sv
// Time-multiplexed, double-buffered driver for NUM_DIGITS common-anode 7-segment digits.
// Optional blink support is compiled in with `define SEG_BLINK_EN.
module seven_segment_scan_driver #(
   parameter int unsigned NUM_DIGITS  = 4,
   parameter int unsigned REFRESH_DIV = 50000,
   parameter int unsigned MAX_VALUE   = 9,
   parameter int unsigned BLINK_DIV   = 64
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic [4*NUM_DIGITS-1:0] digits_in,
   input  logic [NUM_DIGITS-1:0]   blank_in,
`ifdef SEG_BLINK_EN
   input  logic [NUM_DIGITS-1:0]   blink_in,
`endif
   input  logic                    load,
   output logic                    pending,
   output logic [6:0]              segment,
   output logic [NUM_DIGITS-1:0]   anode,
   output logic                    frame_start
);

   localparam int unsigned DATA_W = 4 * NUM_DIGITS;
   localparam int unsigned DIV_W  = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
   localparam int unsigned IDX_W  = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

   generate
      if (NUM_DIGITS < 1 || REFRESH_DIV < 2 || BLINK_DIV < 1) begin : g_bad_param
         $error("seven_segment_scan_driver: illegal parameter value");
      end
   endgenerate

   logic [DIV_W-1:0]      div, div_c;
   logic [IDX_W-1:0]      idx, idx_c;
   logic                  wrapped;
   logic [DATA_W-1:0]     shadow_digits, active_digits;
   logic [NUM_DIGITS-1:0] shadow_blank, active_blank;
   logic                  div_end_c, boundary_c, dark_c;
   logic [3:0]            code_c;
   logic [6:0]            segment_c;
   logic [NUM_DIGITS-1:0] anode_c, blink_mask_c;

   // Glyph for one code; anything above MAX_VALUE renders as a dash
   function automatic logic [6:0] glyph(input logic [3:0] code);
      logic [6:0] g;
      case (code)
         4'h0:    g = 7'b0000001;
         4'h1:    g = 7'b1001111;
         4'h2:    g = 7'b0010010;
         4'h3:    g = 7'b0000110;
         4'h4:    g = 7'b1001100;
         4'h5:    g = 7'b0100100;
         4'h6:    g = 7'b0100000;
         4'h7:    g = 7'b0001111;
         4'h8:    g = 7'b0000000;
         4'h9:    g = 7'b0000100;
         4'hA:    g = 7'b0001000;
         4'hB:    g = 7'b1100000;
         4'hC:    g = 7'b0110001;
         4'hD:    g = 7'b1000010;
         4'hE:    g = 7'b0110000;
         default: g = 7'b0111000;
      endcase
      if (32'(code) > MAX_VALUE) g = 7'b1111110;
      return g;
   endfunction

`ifdef SEG_BLINK_EN
   localparam int unsigned FRM_W = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

   logic [FRM_W-1:0]      frame_cnt;
   logic                  phase_on;
   logic [NUM_DIGITS-1:0] shadow_blink, active_blink;

   // Frame counter paces the blink phase; blink bits follow the same double buffer
   always_ff @(posedge clk) begin
      if (reset) begin
         frame_cnt    <= '0;
         phase_on     <= 1'b1;
         shadow_blink <= '0;
         active_blink <= '0;
      end else begin
         if (boundary_c) begin
            if (frame_cnt == FRM_W'(BLINK_DIV - 1)) begin
               frame_cnt <= '0;
               phase_on  <= ~phase_on;
            end else begin
               frame_cnt <= frame_cnt + FRM_W'(1);
            end
            if (pending) active_blink <= shadow_blink;
         end
         if (load) shadow_blink <= blink_in;
      end
   end

   assign blink_mask_c = phase_on ? '0 : active_blink;
`else
   assign blink_mask_c = '0;
`endif

   // Scan sequencing and the glyph/anode for the digit currently indexed
   always_comb begin
      div_c     = div + DIV_W'(1);
      idx_c     = idx;
      code_c    = 4'h0;
      dark_c    = 1'b0;
      anode_c   = '1;
      div_end_c = (div == DIV_W'(REFRESH_DIV - 1));
      boundary_c = div_end_c && (idx == IDX_W'(NUM_DIGITS - 1));
      if (div_end_c) begin
         div_c = '0;
         idx_c = boundary_c ? '0 : idx + IDX_W'(1);
      end
      for (int i = 0; i < NUM_DIGITS; i++) begin
         if (idx == IDX_W'(i)) begin
            code_c     = active_digits[4*i +: 4];
            dark_c     = active_blank[i] | blink_mask_c[i];
            anode_c[i] = 1'b0;
         end
      end
      segment_c = dark_c ? 7'b1111111 : glyph(code_c);
   end

   // Registered state; a load on the boundary cycle lands in the shadow after the transfer
   always_ff @(posedge clk) begin
      if (reset) begin
         div           <= '0;
         idx           <= '0;
         wrapped       <= 1'b0;
         shadow_digits <= '0;
         shadow_blank  <= '0;
         active_digits <= '0;
         active_blank  <= '0;
         pending       <= 1'b0;
         segment       <= 7'b1111111;
         anode         <= '1;
         frame_start   <= 1'b0;
      end else begin
         div         <= div_c;
         idx         <= idx_c;
         wrapped     <= boundary_c;
         segment     <= segment_c;
         anode       <= anode_c;
         frame_start <= wrapped;
         if (boundary_c && pending) begin
            active_digits <= shadow_digits;
            active_blank  <= shadow_blank;
            pending       <= 1'b0;
         end
         if (load) begin
            shadow_digits <= digits_in;
            shadow_blank  <= blank_in;
            pending       <= 1'b1;
         end
      end
   end

endmodule
